// File: rtl/ctrl_decode_pkg.sv
// Shared control-decode definitions: opcode/function encodings, ALU operations
// and the packed control word carried across the ID/EX boundary.
package ctrl_decode_pkg;

    localparam int unsigned OP_RTYPE = 0;
    localparam int unsigned OP_LW    = 1;
    localparam int unsigned OP_SW    = 2;
    localparam int unsigned OP_ADDI  = 3;
    localparam int unsigned OP_BEQ   = 4;
    localparam int unsigned OP_BNE   = 5;
    localparam int unsigned OP_JMP   = 6;

    localparam int unsigned FN_ADD = 0;
    localparam int unsigned FN_SUB = 1;
    localparam int unsigned FN_SLL = 2;
    localparam int unsigned FN_AND = 3;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_SLL = 2;
    localparam int unsigned ALU_AND = 3;

    typedef struct packed {
        logic reg_write;
        logic branch;
        logic jump;
        logic mem_read;
        logic mem_write;
        logic reg_write_src;
        logic alu_src;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode/function decoder: control word, ALU operation,
// illegal flag and which register sources the instruction reads.
module ctrl_decode_comb
    import ctrl_decode_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int FNW    = 4,
    parameter int ALUOPW = 4
) (
    input  logic [OPW-1:0]    opcode_i,
    input  logic [FNW-1:0]    function_code_i,
    output ctrl_word_t        ctrl_o,
    output logic [ALUOPW-1:0] aluop_o,
    output logic              illegal_o,
    output logic              rtype_o,
    output logic              use_rs_o,
    output logic              use_rt_o
);

    always_comb begin
        ctrl_o    = '0;
        aluop_o   = '0;
        illegal_o = 1'b0;
        rtype_o   = 1'b0;
        use_rs_o  = 1'b0;
        use_rt_o  = 1'b0;
        case (opcode_i)
            OPW'(OP_RTYPE): begin
                rtype_o = 1'b1;
                // Undefined functions decode to a dead word that reads no sources.
                if (function_code_i <= FNW'(FN_AND)) begin
                    ctrl_o.reg_write = 1'b1;
                    aluop_o          = ALUOPW'(function_code_i[1:0]);
                    use_rs_o         = 1'b1;
                    use_rt_o         = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPW'(OP_LW): begin
                ctrl_o.reg_write     = 1'b1;
                ctrl_o.reg_write_src = 1'b1;
                ctrl_o.alu_src       = 1'b1;
                ctrl_o.mem_read      = 1'b1;
                aluop_o              = ALUOPW'(ALU_ADD);
                use_rs_o             = 1'b1;
            end
            OPW'(OP_SW): begin
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                aluop_o          = ALUOPW'(ALU_ADD);
                use_rs_o         = 1'b1;
                use_rt_o         = 1'b1;
            end
            OPW'(OP_ADDI): begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                aluop_o          = ALUOPW'(ALU_ADD);
                use_rs_o         = 1'b1;
            end
            OPW'(OP_BEQ), OPW'(OP_BNE): begin
                ctrl_o.branch = 1'b1;
                aluop_o       = ALUOPW'(ALU_SUB);
                use_rs_o      = 1'b1;
                use_rt_o      = 1'b1;
            end
            OPW'(OP_JMP): begin
                ctrl_o.jump = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: valid/ready intake from fetch, ID/EX output register,
// load-use scoreboard and flush.
module ctrl_decode_stage
    import ctrl_decode_pkg::*;
#(
    parameter int OPW        = 4,
    parameter int FNW        = 4,
    parameter int REGW       = 3,
    parameter int ALUOPW     = 4,
    parameter int LU_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPW-1:0]    opcode,
    input  logic [FNW-1:0]    function_code,
    input  logic [REGW-1:0]   rs,
    input  logic [REGW-1:0]   rt,
    input  logic [REGW-1:0]   rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWrite,
    output logic              Branch,
    output logic              Jump,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              RegWriteSource,
    output logic              ALUSource,
    output logic [ALUOPW-1:0] ALUop,
    output logic [REGW-1:0]   dst,
    output logic              illegal
);

    // The lw sitting in the output register already costs the first bubble, so
    // the counter only has to cover the remaining LU_BUBBLES-1 cycles.
    localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

    ctrl_word_t        dec_ctrl;
    logic [ALUOPW-1:0] dec_aluop;
    logic              dec_illegal, dec_rtype, dec_use_rs, dec_use_rt;
    logic [REGW-1:0]   dec_dst;

    ctrl_word_t        ctrl_q, ctrl_d;
    logic [ALUOPW-1:0] aluop_q, aluop_d;
    logic [REGW-1:0]   dst_q, dst_d;
    logic              illegal_q, illegal_d;
    logic              out_valid_q, out_valid_d;
    logic [REGW-1:0]   lu_dst_q, lu_dst_d;
    logic [1:0]        lu_cnt_q, lu_cnt_d;

    logic rs_hit, rt_hit, hazard, accept, xfer;

    ctrl_decode_comb #(
        .OPW    (OPW),
        .FNW    (FNW),
        .ALUOPW (ALUOPW)
    ) u_dec (
        .opcode_i        (opcode),
        .function_code_i (function_code),
        .ctrl_o          (dec_ctrl),
        .aluop_o         (dec_aluop),
        .illegal_o       (dec_illegal),
        .rtype_o         (dec_rtype),
        .use_rs_o        (dec_use_rs),
        .use_rt_o        (dec_use_rt)
    );

    assign dec_dst = dec_rtype ? rd : rt;

    assign rs_hit = dec_use_rs && (rs != '0) &&
                    ((out_valid_q && ctrl_q.mem_read && (dst_q == rs)) ||
                     ((lu_cnt_q != 2'd0) && (lu_dst_q == rs)));
    assign rt_hit = dec_use_rt && (rt != '0) &&
                    ((out_valid_q && ctrl_q.mem_read && (dst_q == rt)) ||
                     ((lu_cnt_q != 2'd0) && (lu_dst_q == rt)));
    assign hazard = in_valid && (rs_hit || rt_hit);

    // Handshake: a word moves on an edge where valid && ready are both high;
    // valid never depends on ready, and a held word keeps its payload stable.
    assign in_ready = rst_n && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        aluop_d     = aluop_q;
        dst_d       = dst_q;
        illegal_d   = illegal_q;
        lu_dst_d    = lu_dst_q;
        lu_cnt_d    = lu_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            lu_cnt_d    = 2'd0;
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
                ctrl_d      = dec_ctrl;
                aluop_d     = dec_aluop;
                dst_d       = dec_dst;
                illegal_d   = dec_illegal;
            end else if (xfer) begin
                out_valid_d = 1'b0;
            end
            if (xfer && ctrl_q.mem_read) begin
                lu_dst_d = dst_q;
                lu_cnt_d = LU_LOAD;
            end else if (lu_cnt_q != 2'd0) begin
                lu_cnt_d = lu_cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            aluop_q     <= '0;
            dst_q       <= '0;
            illegal_q   <= 1'b0;
            lu_dst_q    <= '0;
            lu_cnt_q    <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            aluop_q     <= aluop_d;
            dst_q       <= dst_d;
            illegal_q   <= illegal_d;
            lu_dst_q    <= lu_dst_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign RegWrite       = ctrl_q.reg_write;
    assign Branch         = ctrl_q.branch;
    assign Jump           = ctrl_q.jump;
    assign MemRead        = ctrl_q.mem_read;
    assign MemWrite       = ctrl_q.mem_write;
    assign RegWriteSource = ctrl_q.reg_write_src;
    assign ALUSource      = ctrl_q.alu_src;
    assign ALUop          = aluop_q;
    assign dst            = dst_q;
    assign illegal        = illegal_q;

endmodule
